// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXIS state encoding and default widths
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 8;
    localparam int AXIS_LEN_WIDTH  = 8;
    localparam int AXIS_GAP_WIDTH  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/axis_packet_gen_if.sv
// rtl/axis_packet_gen_if.sv - AXIS beat channel between a source and a sink
interface axis_packet_gen_if #(
    parameter int DATA_WIDTH = axis_pkg::AXIS_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  last;
    logic                  ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_packet_gen.sv
// rtl/axis_packet_gen.sv - burst generator of incrementing-data AXIS packets
module axis_packet_gen
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXIS_LEN_WIDTH,
    parameter int GAP_WIDTH  = AXIS_GAP_WIDTH
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [LEN_WIDTH-1:0]  num_pkts,
    input  logic [GAP_WIDTH-1:0]  gap,
    input  logic [DATA_WIDTH-1:0] seed,
    axis_packet_gen_if.master     m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  pkt_count
);

    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  num_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    logic [LEN_WIDTH-1:0]  beat_next;
    logic [LEN_WIDTH-1:0]  pkt_next;
    logic                  xfer;

    assign beat_next = beat_cnt + LEN_WIDTH'(1);
    assign pkt_next  = pkt_count + LEN_WIDTH'(1);
    assign xfer      = valid_q & m_axis.ready;

    assign m_axis.data  = data_q;
    assign m_axis.valid = valid_q;
    assign m_axis.last  = last_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            beat_cnt  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (pkt_len != '0) && (num_pkts != '0)) begin
                        len_q     <= pkt_len;
                        num_q     <= num_pkts;
                        gap_q     <= gap;
                        data_q    <= seed;
                        pkt_count <= '0;
                        beat_cnt  <= LEN_WIDTH'(1);
                        valid_q   <= 1'b1;
                        last_q    <= (pkt_len == LEN_WIDTH'(1));
                        busy      <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        data_q <= data_q + DATA_WIDTH'(1);
                        if (last_q) begin
                            pkt_count <= pkt_next;
                            if (pkt_next == num_q) begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state   <= ST_IDLE;
                            end else if (gap_q == '0) begin
                                // back-to-back: next packet's first beat goes out next cycle
                                beat_cnt <= LEN_WIDTH'(1);
                                last_q   <= (len_q == LEN_WIDTH'(1));
                            end else begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                gap_cnt <= gap_q;
                                state   <= ST_GAP;
                            end
                        end else begin
                            beat_cnt <= beat_next;
                            last_q   <= (beat_next == len_q);
                        end
                    end
                end
                ST_GAP: begin
                    // raise valid on the final gap cycle so it is seen exactly gap cycles later
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        beat_cnt <= LEN_WIDTH'(1);
                        valid_q  <= 1'b1;
                        last_q   <= (len_q == LEN_WIDTH'(1));
                        state    <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
